spi_flash_read_ctrl: RTL and testbench
======================================

// Module: spi_flash_read_ctrl
// PURPOSE
//  Single-bit SPI (mode 0) read initiator for the external boot flash; it is the
//  host end of the link that the spiflash model answers. Per accepted request it
//  issues READ (0x03) + 24-bit address, then shifts in one 32-bit little-endian
//  word. Optional one-time 0xAB release-from-power-down after reset. Feeds the
//  mgmt fetch path and gives the bench a driver that does not need the full core.
// PARAMETERS
//  DIV        2  flash_clk half-period in core_clk cycles; legal range 1..255
//  CS_GAP     2  minimum core_clk cycles flash_csb stays high between transfers (>=1)
//  WAKEUP     1  1: send 0xAB once after reset before first READ; 0: skip
// PORTS
//  core_clk       in   1   system clock
//  core_rstn      in   1   asynchronous active-low reset
//  req_valid      in   1   read request; held with req_addr until accepted
//  req_ready      out  1   high only in IDLE; accept = req_valid & req_ready
//  req_addr       in   24  flash byte address (no alignment requirement)
//  rsp_valid      out  1   one-cycle pulse: rsp_data valid; no backpressure
//  rsp_data       out  32  {byte@a+3, a+2, a+1, a}; held until next rsp_valid
//  busy           out  1   high in every state except IDLE
//  flash_csb      out  1   chip select, active low
//  flash_clk      out  1   SPI clock; low whenever flash_csb is high
//  flash_io0_do   out  1   MOSI
//  flash_io0_oeb  out  1   io0 output enable, active low
//  flash_io1_di   in   1   MISO
// BEHAVIOUR
//  Reset (async): flash_csb=1, flash_clk=0, io0_do=0, io0_oeb=1, req_ready=0,
//   rsp_valid=0, rsp_data=0, busy=1; state = WAKE_GAP (WAKEUP=1) else GAP.
//  States: WAKE_GAP -> WAKE -> GAP -> IDLE -> SHIFT -> DONE -> GAP.
//  WAKE_GAP: CS_GAP cycles csb high, then WAKE. WAKE: 8-bit frame 0xAB, io0_oeb=0,
//   then csb high -> GAP. WAKE never reruns until next reset.
//  GAP: csb high for CS_GAP cycles, then IDLE. IDLE: req_ready=1, busy=0.
//  Bit timing (all frames): accept/entry at cycle T; T+1 csb=0, bit0 driven on io0;
//   flash_clk rises at T+1+(2k+1)*DIV for bit k (k from 0), falls at T+1+(2k+2)*DIV;
//   next output bit changes on that falling edge. MISO sampled on rising edge.
//   All bits MSB-first within each byte.
//  SHIFT (64 bits): k=0..7 cmd 0x03, k=8..31 req_addr[23:0] MSB first, io0_oeb=0;
//   k=32..63 data phase: io0_oeb=1, io0_do=0. Byte n of data (k=32+8n..) lands
//   in rsp_data[8n+7:8n].
//  DONE: at T+1+128*DIV (last falling edge) csb=1, flash_clk=0, rsp_valid=1 for
//   exactly one cycle, rsp_data updated same cycle; then GAP. DIV=2 -> T+257.
//  req_addr captured at accept; later changes ignored. Request held while not
//   ready is not lost; req_valid dropping before accept is legal (no transfer).
//  Address 0xFFFFFF: sent as-is; wrap to 0 is the flash's concern, not ours.
//  Bit counter 7-bit, divider counter 8-bit; no other arithmetic.
//  Reset mid-frame: outputs go to reset values immediately (csb high aborts the
//   flash command); no rsp_valid for the aborted request; WAKE repeats if WAKEUP=1.
//  flash_io0_oeb=1 whenever csb=1.
// TESTING
//  1 reset, WAKEUP=1, DIV=2, CS_GAP=2: first csb-low frame carries 0xAB (8 clks),
//    then req_ready=1; no rsp_valid; flash_clk low whenever csb high.
//  2 spiflash loaded 0x00:EF BE AD DE, req 0x000000 -> rsp_valid at accept+257,
//    rsp_data=0xDEADBEEF; io0 bits seen = 0x03,0x00,0x00,0x00; 32 clks on data phase.
//  3 back-to-back req 0x000004 held high -> second csb fall >=CS_GAP+1 cycles after
//    first csb rise; each accept exactly one rsp_valid; req_ready=0 while busy.
//  4 DIV=1 and DIV=5 -> flash_clk high/low widths 1 and 5 cycles; latency 129 / 641.
//  5 assert core_rstn low at data bit 40 -> csb=1, clk=0, oeb=1 same cycle;
//    no rsp_valid; after release WAKE frame then a fresh read returns correct word.
//  6 req_addr=0xFFFFFC, change req_addr after accept -> transmitted address stays
//    0xFFFFFC; rsp_data matches flash bytes 0xFFFFFC..0xFFFFFF.

Source files
------------

// File: rtl/spi_flash_read_ctrl.sv
// spi_flash_read_ctrl
//   Single-bit SPI mode-0 read initiator for the external boot flash. Each
//   accepted request sends READ (0x03) plus a 24-bit address and then shifts
//   in one 32-bit little-endian word. It can optionally send a single 0xAB
//   release-from-power-down frame after reset.
//
// Ports
//   core_clk, core_rstn      clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake; req_addr is sampled on accept
//   req_addr[23:0]           flash byte address
//   rsp_valid                one-cycle pulse when rsp_data is updated
//   rsp_data[31:0]           {byte@a+3, byte@a+2, byte@a+1, byte@a}
//   busy                     high in every state except IDLE
//   flash_csb, flash_clk     SPI chip select (active low) and SPI clock
//   flash_io0_do/_oeb        MOSI and its active-low output enable
//   flash_io1_di             MISO
//
// State table
//   state      | meaning
//   WAKE_GAP   | csb high for CS_GAP cycles before the wake frame
//   WAKE       | 8-bit 0xAB frame on io0
//   GAP        | csb high for CS_GAP cycles between frames
//   IDLE       | ready for a request
//   SHIFT      | 64-bit READ frame: 8 cmd + 24 addr out, 32 data in
//   DONE       | csb high, rsp_valid pulse, then GAP

module spi_flash_read_ctrl #(
  parameter int unsigned DIV    = 2,
  parameter int unsigned CS_GAP = 2,
  parameter bit          WAKEUP = 1'b1
) (
  input  logic        core_clk,
  input  logic        core_rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0_do,
  output logic        flash_io0_oeb,
  input  logic        flash_io1_di
);

  typedef enum logic [2:0] {
    S_WAKE_GAP = 3'd0,
    S_WAKE     = 3'd1,
    S_GAP      = 3'd2,
    S_IDLE     = 3'd3,
    S_SHIFT    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam state_t     RESET_STATE = WAKEUP ? S_WAKE_GAP : S_GAP;
  localparam logic [7:0] DIV_LOAD    = 8'(DIV - 1);
  localparam logic [7:0] GAP_LOAD    = 8'(CS_GAP - 1);
  localparam logic [7:0] CMD_READ    = 8'h03;
  localparam logic [7:0] CMD_WAKE    = 8'hAB;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  div_cnt;
  logic [6:0]  bit_cnt;
  logic        clk_q;
  logic [31:0] tx_shift;
  logic [31:0] rx_shift;
  logic [31:0] rx_word;

  logic        in_frame;
  logic        tick;
  logic        last_bit;
  logic        frame_end;
  logic        out_phase;

  // The divider counter doubles as the csb-high gap timer outside frames.
  assign in_frame  = (state == S_WAKE) || (state == S_SHIFT);
  assign tick      = (div_cnt == 8'd0);
  assign last_bit  = (state == S_WAKE) ? (bit_cnt == 7'd7) : (bit_cnt == 7'd63);
  assign frame_end = in_frame & tick & clk_q & last_bit;
  assign out_phase = (state == S_WAKE) || (bit_cnt < 7'd32);

  // Bytes arrive first-address-first, so the first byte shifted in ends up in
  // rx_shift[31:24] and must move to the least-significant byte.
  assign rx_word = {rx_shift[7:0], rx_shift[15:8], rx_shift[23:16], rx_shift[31:24]};

  // State register
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      state <= RESET_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_WAKE_GAP: if (tick)      state_nxt = S_WAKE;
      S_WAKE:     if (frame_end) state_nxt = S_GAP;
      S_GAP:      if (tick)      state_nxt = S_IDLE;
      S_IDLE:     if (req_valid) state_nxt = S_SHIFT;
      S_SHIFT:    if (frame_end) state_nxt = S_DONE;
      S_DONE:                    state_nxt = S_GAP;
      default:                   state_nxt = RESET_STATE;
    endcase
  end

  // Output logic; everything the pins see is decoded from registered state,
  // so an async reset forces the idle pin levels in the same cycle.
  always_comb begin
    flash_csb     = 1'b1;
    flash_io0_oeb = 1'b1;
    flash_io0_do  = 1'b0;
    req_ready     = 1'b0;
    busy          = 1'b1;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_WAKE, S_SHIFT: begin
        flash_csb = 1'b0;
        if (out_phase) begin
          flash_io0_oeb = 1'b0;
          flash_io0_do  = tx_shift[31];
        end
      end
      default: ;
    endcase
    flash_clk = clk_q & in_frame;
  end

  // Bit timing, shift registers and response
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      div_cnt   <= GAP_LOAD;
      bit_cnt   <= 7'd0;
      clk_q     <= 1'b0;
      tx_shift  <= 32'd0;
      rx_shift  <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_WAKE_GAP: begin
          if (tick) begin
            div_cnt  <= DIV_LOAD;
            bit_cnt  <= 7'd0;
            clk_q    <= 1'b0;
            tx_shift <= {CMD_WAKE, 24'h000000};
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        S_GAP: begin
          if (!tick) div_cnt <= div_cnt - 8'd1;
        end
        S_IDLE: begin
          if (req_valid) begin
            div_cnt  <= DIV_LOAD;
            bit_cnt  <= 7'd0;
            clk_q    <= 1'b0;
            tx_shift <= {CMD_READ, req_addr};
          end
        end
        S_WAKE, S_SHIFT: begin
          if (!tick) begin
            div_cnt <= div_cnt - 8'd1;
          end else if (!clk_q) begin
            // rising edge: sample MISO
            clk_q    <= 1'b1;
            div_cnt  <= DIV_LOAD;
            rx_shift <= {rx_shift[30:0], flash_io1_di};
          end else begin
            // falling edge: advance to the next bit or close the frame
            clk_q <= 1'b0;
            if (last_bit) begin
              div_cnt <= GAP_LOAD;
              if (state == S_SHIFT) begin
                rsp_valid <= 1'b1;
                rsp_data  <= rx_word;
              end
            end else begin
              div_cnt  <= DIV_LOAD;
              bit_cnt  <= bit_cnt + 7'd1;
              tx_shift <= {tx_shift[30:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_read_ctrl.sv
module tb_spi_flash_read_ctrl;

  localparam int DIV    = 2;
  localparam int CS_GAP = 2;

  logic core_clk  = 1'b0;
  logic core_rstn = 1'b1;
  always #5 core_clk = ~core_clk;

  int cyc = 0;
  always @(posedge core_clk) cyc <= cyc + 1;

  // main instance (DIV=2) with a behavioural flash behind it
  logic        req_valid = 1'b0;
  logic [23:0] req_addr  = 24'h0;
  logic        req_ready, rsp_valid, busy;
  logic [31:0] rsp_data;
  logic        flash_csb, flash_clk, flash_io0_do, flash_io0_oeb;
  logic        flash_io1_di = 1'b0;

  spi_flash_read_ctrl #(.DIV(DIV), .CS_GAP(CS_GAP), .WAKEUP(1'b1)) u_dut (
    .core_clk(core_clk), .core_rstn(core_rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .flash_csb(flash_csb), .flash_clk(flash_clk),
    .flash_io0_do(flash_io0_do), .flash_io0_oeb(flash_io0_oeb),
    .flash_io1_di(flash_io1_di)
  );

  // timing-only instances: index 0 is DIV=1, index 1 is DIV=5; MISO held high
  logic [1:0]  aux_valid = 2'b00;
  logic [23:0] aux_addr  = 24'h000100;
  logic [1:0]  aux_ready, aux_rsp_valid, aux_busy, aux_csb, aux_clk, aux_do, aux_oeb;
  logic [31:0] aux_data [2];

  spi_flash_read_ctrl #(.DIV(1), .CS_GAP(CS_GAP), .WAKEUP(1'b1)) u_div1 (
    .core_clk(core_clk), .core_rstn(core_rstn),
    .req_valid(aux_valid[0]), .req_ready(aux_ready[0]), .req_addr(aux_addr),
    .rsp_valid(aux_rsp_valid[0]), .rsp_data(aux_data[0]), .busy(aux_busy[0]),
    .flash_csb(aux_csb[0]), .flash_clk(aux_clk[0]),
    .flash_io0_do(aux_do[0]), .flash_io0_oeb(aux_oeb[0]),
    .flash_io1_di(1'b1)
  );

  spi_flash_read_ctrl #(.DIV(5), .CS_GAP(CS_GAP), .WAKEUP(1'b1)) u_div5 (
    .core_clk(core_clk), .core_rstn(core_rstn),
    .req_valid(aux_valid[1]), .req_ready(aux_ready[1]), .req_addr(aux_addr),
    .rsp_valid(aux_rsp_valid[1]), .rsp_data(aux_data[1]), .busy(aux_busy[1]),
    .flash_csb(aux_csb[1]), .flash_clk(aux_clk[1]),
    .flash_io0_do(aux_do[1]), .flash_io0_oeb(aux_oeb[1]),
    .flash_io1_di(1'b1)
  );

  // ---------------- flash contents and reference model ----------------
  logic [7:0] mem [logic [23:0]];

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5C;
  endfunction

  function automatic logic [31:0] ref_word(input logic [23:0] a);
    logic [31:0] w;
    for (int n = 0; n < 4; n++) w[8*n +: 8] = flash_byte(a + 24'(n));
    return w;
  endfunction

  // ---------------- flash model / bus monitor ----------------
  int          rises = 0;
  logic [31:0] mosi = 32'h0;
  logic        prev_csb = 1'b1, prev_clk = 1'b0;
  int          frames = 0, last_rises = 0;
  logic [31:0] last_mosi = 32'h0;
  int          rsp_count = 0, clk_viol = 0, oeb_viol = 0;
  int          last_rise_cyc = 0, min_gap = 1000000;
  int          mj;
  logic [7:0]  mb;

  always @(negedge core_clk) begin
    if (rsp_valid) rsp_count++;
    if (flash_csb) begin
      if (flash_clk) clk_viol++;
      if (!flash_io0_oeb) oeb_viol++;
      if (!prev_csb) begin
        frames++;
        last_rises    = rises;
        last_mosi     = mosi;
        last_rise_cyc = cyc;
      end
      rises = 0;
    end else begin
      if (prev_csb) begin
        if (frames > 0 && (cyc - last_rise_cyc) < min_gap) min_gap = cyc - last_rise_cyc;
        mosi  = 32'h0;
        rises = 0;
      end
      if (flash_clk && !prev_clk) begin
        rises++;
        if (rises <= 32) mosi = {mosi[30:0], flash_io0_do};
      end else if (!flash_clk && prev_clk && rises >= 32 && rises < 64 && mosi[31:24] == 8'h03) begin
        mj = rises - 32;
        mb = flash_byte(mosi[23:0] + 24'(mj / 8));
        flash_io1_di = mb[7 - (mj % 8)];
      end
    end
    prev_csb = flash_csb;
    prev_clk = flash_clk;
  end

  // ---------------- checking ----------------
  int vec = 0, errs = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic do_read(input logic [23:0] a, input bit hold, input bit scramble,
                         input logic [31:0] exp, input string tag);
    int n, t_acc, rc0, ready_busy;
    rc0 = rsp_count;
    @(negedge core_clk);
    req_valid = 1'b1;
    req_addr  = a;
    n = 0;
    while (!req_ready && n < 4000) begin @(negedge core_clk); n++; end
    if (!req_ready) begin
      check({tag, " accept_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    t_acc = cyc;
    @(negedge core_clk);
    if (!hold) req_valid = 1'b0;
    if (scramble) req_addr = ~a;
    n = 0;
    ready_busy = 0;
    while (!rsp_valid && n < 4000) begin
      if (req_ready) ready_busy++;
      @(negedge core_clk);
      n++;
    end
    check({tag, " latency"}, 32'(cyc - t_acc), 32'(1 + 128 * DIV));
    check({tag, " rsp_data"}, rsp_data, exp);
    check({tag, " ready_while_busy"}, 32'(ready_busy), 32'd0);
    @(negedge core_clk);
    check({tag, " rsp_pulses"}, 32'(rsp_count - rc0), 32'd1);
    check({tag, " mosi_cmd_addr"}, last_mosi, {8'h03, a});
    check({tag, " clocks"}, 32'(last_rises), 32'd64);
  endtask

  task automatic aux_read(input int sel, input int div);
    int n, t_acc, run, hmin, hmax, lmin, lmax, highs, viol;
    logic pl, c;
    bit inframe;
    @(negedge core_clk);
    aux_valid[sel] = 1'b1;
    n = 0;
    while (!aux_ready[sel] && n < 4000) begin @(negedge core_clk); n++; end
    if (!aux_ready[sel]) begin
      check("aux accept_timeout", 32'd0, 32'd1);
      aux_valid[sel] = 1'b0;
      return;
    end
    t_acc = cyc;
    hmin = 1000; hmax = 0; lmin = 1000; lmax = 0; highs = 0; viol = 0;
    inframe = 1'b0; run = 0; pl = 1'b0;
    n = 0;
    while (n < 8000) begin
      @(negedge core_clk);
      n++;
      aux_valid[sel] = 1'b0;
      c = aux_clk[sel];
      if (aux_oeb[sel] && aux_do[sel]) viol++;
      if (!aux_csb[sel]) begin
        if (!inframe) begin
          inframe = 1'b1; pl = c; run = 1;
        end else if (c == pl) begin
          run++;
        end else begin
          if (pl) begin highs++; hmin = (run < hmin) ? run : hmin; hmax = (run > hmax) ? run : hmax; end
          else    begin lmin = (run < lmin) ? run : lmin; lmax = (run > lmax) ? run : lmax; end
          pl = c; run = 1;
        end
      end else begin
        if (c) viol++;
        if (inframe) begin
          if (pl) begin highs++; hmin = (run < hmin) ? run : hmin; hmax = (run > hmax) ? run : hmax; end
          else    begin lmin = (run < lmin) ? run : lmin; lmax = (run > lmax) ? run : lmax; end
          inframe = 1'b0;
        end
      end
      if (aux_rsp_valid[sel]) break;
    end
    check($sformatf("div%0d latency", div), 32'(cyc - t_acc), 32'(1 + 128 * div));
    check($sformatf("div%0d rsp_data", div), aux_data[sel], 32'hFFFFFFFF);
    check($sformatf("div%0d busy_at_rsp", div), 32'(aux_busy[sel]), 32'd1);
    check($sformatf("div%0d clk_high_min", div), 32'(hmin), 32'(div));
    check($sformatf("div%0d clk_high_max", div), 32'(hmax), 32'(div));
    check($sformatf("div%0d clk_low_min", div), 32'(lmin), 32'(div));
    check($sformatf("div%0d clk_low_max", div), 32'(lmax), 32'(div));
    check($sformatf("div%0d clocks", div), 32'(highs), 32'd64);
    check($sformatf("div%0d pin_rules", div), 32'(viol), 32'd0);
  endtask

  typedef struct {
    logic [23:0] addr;
    bit          hold;
    bit          scramble;
    logic [31:0] exp;
  } vec_t;

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t tbl[5];
    int   n, rc0, ready_seen;
    bit   prev_hold, hold, scr;
    logic [23:0] a;

    tbl[0] = '{24'h000000, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[1] = '{24'h000004, 1'b1, 1'b0, 32'h44332211};
    tbl[2] = '{24'h000004, 1'b0, 1'b0, 32'h44332211};
    tbl[3] = '{24'h000002, 1'b0, 1'b0, 32'h2211DEAD};
    tbl[4] = '{24'hFFFFFC, 1'b0, 1'b1, 32'h04030201};

    mem[24'h000000] = 8'hEF; mem[24'h000001] = 8'hBE;
    mem[24'h000002] = 8'hAD; mem[24'h000003] = 8'hDE;
    mem[24'h000004] = 8'h11; mem[24'h000005] = 8'h22;
    mem[24'h000006] = 8'h33; mem[24'h000007] = 8'h44;
    mem[24'hFFFFFC] = 8'h01; mem[24'hFFFFFD] = 8'h02;
    mem[24'hFFFFFE] = 8'h03; mem[24'hFFFFFF] = 8'h04;

    // reset values
    #2 core_rstn = 1'b0;
    repeat (2) @(negedge core_clk);
    check("rst csb",       32'(flash_csb),     32'd1);
    check("rst clk",       32'(flash_clk),     32'd0);
    check("rst io0_do",    32'(flash_io0_do),  32'd0);
    check("rst io0_oeb",   32'(flash_io0_oeb), 32'd1);
    check("rst req_ready", 32'(req_ready),     32'd0);
    check("rst rsp_valid", 32'(rsp_valid),     32'd0);
    check("rst rsp_data",  rsp_data,           32'd0);
    check("rst busy",      32'(busy),          32'd1);
    core_rstn = 1'b1;

    // a request dropped before it is accepted must not start a transfer
    ready_seen = 0;
    req_valid = 1'b1;
    repeat (3) begin @(negedge core_clk); if (req_ready) ready_seen++; end
    req_valid = 1'b0;
    check("early ready", 32'(ready_seen), 32'd0);
    n = 0;
    while (!req_ready && n < 2000) begin @(negedge core_clk); n++; end
    check("wake ready", 32'(req_ready), 32'd1);
    repeat (10) @(negedge core_clk);
    check("wake frames", 32'(frames), 32'd1);
    check("wake byte", last_mosi, 32'h000000AB);
    check("wake clocks", 32'(last_rises), 32'd8);
    check("wake no rsp", 32'(rsp_count), 32'd0);
    check("idle busy", 32'(busy), 32'd0);

    // directed reads, including back-to-back and address change after accept
    for (int i = 0; i < 5; i++)
      do_read(tbl[i].addr, tbl[i].hold, tbl[i].scramble, tbl[i].exp, $sformatf("tbl%0d", i));
    check("cs gap >= CS_GAP+1", 32'(min_gap >= CS_GAP + 1), 32'd1);

    // randomized reads against the reference model
    prev_hold = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a    = 24'($urandom);
      hold = (i < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
      scr  = !hold && ($urandom_range(0, 1) == 1);
      if (!prev_hold) repeat ($urandom_range(0, 5)) @(negedge core_clk);
      do_read(a, hold, scr, ref_word(a), $sformatf("rnd%0d", i));
      prev_hold = hold;
    end

    // reset in the middle of the data phase
    @(negedge core_clk);
    req_valid = 1'b1;
    req_addr  = 24'h000010;
    n = 0;
    while (!req_ready && n < 2000) begin @(negedge core_clk); n++; end
    @(negedge core_clk);
    req_valid = 1'b0;
    n = 0;
    while (rises < 41 && n < 2000) begin @(negedge core_clk); n++; end
    check("abort reached bit 40", 32'(rises >= 41), 32'd1);
    rc0 = rsp_count;
    core_rstn = 1'b0;
    #1;
    check("abort csb", 32'(flash_csb),     32'd1);
    check("abort clk", 32'(flash_clk),     32'd0);
    check("abort oeb", 32'(flash_io0_oeb), 32'd1);
    check("abort busy", 32'(busy),         32'd1);
    repeat (3) @(negedge core_clk);
    core_rstn = 1'b1;
    n = 0;
    while (!req_ready && n < 2000) begin @(negedge core_clk); n++; end
    check("abort ready", 32'(req_ready), 32'd1);
    check("abort no rsp", 32'(rsp_count - rc0), 32'd0);
    check("rewake byte", last_mosi, 32'h000000AB);
    check("rewake clocks", 32'(last_rises), 32'd8);
    do_read(24'h000000, 1'b0, 1'b0, 32'hDEADBEEF, "post_abort");

    // clock divider extremes
    aux_read(0, 1);
    aux_read(1, 5);

    check("clk low while csb high", 32'(clk_viol), 32'd0);
    check("oeb high while csb high", 32'(oeb_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
